// File: rtl/prog_loader.sv
// Program loader: streams bytes into memory from address 0 up to a captured last address,
// then takes one checksum byte. A zero byte-sum releases the processor from reset; any
// other sum parks the block in an error state.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              ldr_clk,
  input  logic              ldr_rst,
  input  logic              ldr_start,
  input  logic [ADDR_W-1:0] ldr_last_addr,
  input  logic [DATA_W-1:0] ldr_in_data,
  input  logic              ldr_in_valid,
  output logic              ldr_in_ready,
  output logic [ADDR_W-1:0] ldr_mem_addr,
  output logic [DATA_W-1:0] ldr_mem_data,
  output logic              ldr_mem_wr_en,
  output logic              ldr_cpu_rst,
  output logic              ldr_busy,
  output logic              ldr_done,
  output logic              ldr_err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StRun   = 3'd3,
    StErr   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;

  logic              accepting;
  logic              xfer;
  logic [DATA_W-1:0] sum_next;

  // Only LOAD and CHECK consume bytes; readiness depends on state alone.
  assign accepting = (state_q == StLoad) || (state_q == StCheck);
  assign xfer      = ldr_in_valid & accepting;
  assign sum_next  = sum_q + ldr_in_data;

  // Next-state and datapath: start overrides any coincident transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;

    if (ldr_start) begin
      state_d = StLoad;
      cnt_d   = '0;
      sum_d   = '0;
      last_d  = ldr_last_addr;
    end else if (xfer) begin
      unique case (state_q)
        StLoad: begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          data_d = ldr_in_data;
          sum_d  = sum_next;
          // Stop at the captured last address so the counter never wraps.
          if (cnt_q == last_q) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCheck: begin
          // Checksum byte is folded into the sum but never written.
          state_d = (sum_next == '0) ? StRun : StErr;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers; reset also kills any pending write strobe.
  always_ff @(posedge ldr_clk or posedge ldr_rst) begin
    if (ldr_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Outputs are registers or pure state decodes.
  always_comb begin
    ldr_in_ready  = accepting;
    ldr_busy      = accepting;
    ldr_done      = (state_q == StRun);
    ldr_err       = (state_q == StErr);
    ldr_cpu_rst   = (state_q != StRun);
    ldr_mem_wr_en = wr_q;
    ldr_mem_addr  = addr_q;
    ldr_mem_data  = data_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: transaction-level model plus directed scenarios.
module tb_prog_loader;

  localparam int PIdle  = 0;
  localparam int PLoad  = 1;
  localparam int PCheck = 2;
  localparam int PRun   = 3;
  localparam int PErr   = 4;

  logic       ldr_clk, ldr_rst, ldr_start, ldr_in_valid;
  logic [7:0] ldr_last_addr, ldr_in_data;
  logic       ldr_in_ready, ldr_mem_wr_en, ldr_cpu_rst, ldr_busy, ldr_done, ldr_err;
  logic [7:0] ldr_mem_addr, ldr_mem_data;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: bytes accepted in the current load, and the expected write for this cycle.
  int   m_phase;
  int   m_last;
  int   m_bytes[$];
  logic m_wr;
  int   m_addr;
  int   m_data;

  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .ldr_clk      (ldr_clk),
    .ldr_rst      (ldr_rst),
    .ldr_start    (ldr_start),
    .ldr_last_addr(ldr_last_addr),
    .ldr_in_data  (ldr_in_data),
    .ldr_in_valid (ldr_in_valid),
    .ldr_in_ready (ldr_in_ready),
    .ldr_mem_addr (ldr_mem_addr),
    .ldr_mem_data (ldr_mem_data),
    .ldr_mem_wr_en(ldr_mem_wr_en),
    .ldr_cpu_rst  (ldr_cpu_rst),
    .ldr_busy     (ldr_busy),
    .ldr_done     (ldr_done),
    .ldr_err      (ldr_err)
  );

  initial begin
    ldr_clk = 1'b0;
    forever #5 ldr_clk = ~ldr_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsum();
    int s = 0;
    foreach (m_bytes[i]) s += m_bytes[i];
    return s;
  endfunction

  // Behavioural model, stepped on each edge from the sampled inputs.
  always @(posedge ldr_clk or posedge ldr_rst) begin
    if (ldr_rst) begin
      m_phase = PIdle;
      m_wr    = 1'b0;
      m_addr  = 0;
      m_data  = 0;
      m_bytes.delete();
    end else begin
      m_wr = 1'b0;
      if (ldr_start) begin
        m_phase = PLoad;
        m_last  = int'(ldr_last_addr);
        m_bytes.delete();
      end else if (ldr_in_valid && m_phase == PLoad) begin
        m_wr   = 1'b1;
        m_addr = m_bytes.size();
        m_data = int'(ldr_in_data);
        m_bytes.push_back(int'(ldr_in_data));
        if (m_bytes.size() == m_last + 1) m_phase = PCheck;
      end else if (ldr_in_valid && m_phase == PCheck) begin
        m_phase = (((qsum() + int'(ldr_in_data)) % 256) == 0) ? PRun : PErr;
      end
    end
  end

  // Compare every cycle, mid-period, and log observed writes.
  always @(negedge ldr_clk) begin
    chk("wr_en", ldr_mem_wr_en, m_wr);
    if (m_wr) begin
      chk("mem_addr", ldr_mem_addr, m_addr);
      chk("mem_data", ldr_mem_data, m_data);
    end
    chk("in_ready", ldr_in_ready, m_phase == PLoad || m_phase == PCheck);
    chk("busy", ldr_busy, m_phase == PLoad || m_phase == PCheck);
    chk("done", ldr_done, m_phase == PRun);
    chk("err", ldr_err, m_phase == PErr);
    chk("cpu_rst", ldr_cpu_rst, m_phase != PRun);
    if (ldr_mem_wr_en) log_q.push_back({ldr_mem_addr, ldr_mem_data});
  end

  task automatic do_start();
    ldr_start = 1'b1;
    @(negedge ldr_clk);
    ldr_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!ldr_in_ready && n < 20) begin
      @(negedge ldr_clk);
      n++;
    end
    if (!ldr_in_ready) chk("ready_timeout", ldr_in_ready, 1);
    ldr_in_valid = 1'b1;
    ldr_in_data  = b;
    @(negedge ldr_clk);
    ldr_in_valid = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    ldr_in_valid = v;
    ldr_in_data  = d;
    @(negedge ldr_clk);
    ldr_in_valid = 1'b0;
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_nwr"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({nm, "_wr"}, log_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ldr_rst = 1'b1; ldr_start = 1'b0; ldr_in_valid = 1'b0;
    ldr_in_data = 8'h00; ldr_last_addr = 8'h00;
    repeat (3) @(negedge ldr_clk);
    chk("rst_cpu_rst", ldr_cpu_rst, 1);
    chk("rst_ready", ldr_in_ready, 0);
    chk("rst_addr", ldr_mem_addr, 0);
    chk("rst_data", ldr_mem_data, 0);
    ldr_rst = 1'b0;
    // Idle must ignore data until start.
    repeat (3) cyc(1'b1, 8'h55);
    chk("idle_busy", ldr_busy, 0);

    // Good load; changing last_addr after start must not matter.
    log_q.delete();
    ldr_last_addr = 8'd2;
    do_start();
    ldr_last_addr = 8'd0;
    send(8'h10); send(8'h20); send(8'h30); send(8'hA0);
    repeat (2) @(negedge ldr_clk);
    exp_q = {16'h0010, 16'h0120, 16'h0230};
    check_log("good");
    chk("good_done", ldr_done, 1);
    chk("good_cpu_rst", ldr_cpu_rst, 0);
    repeat (3) cyc(1'b1, 8'h77);
    chk("run_hold", ldr_done, 1);

    // Bad checksum.
    log_q.delete();
    ldr_last_addr = 8'd2;
    do_start();
    send(8'h10); send(8'h20); send(8'h30); send(8'hA1);
    repeat (2) @(negedge ldr_clk);
    check_log("bad");
    chk("bad_err", ldr_err, 1);
    chk("bad_cpu_rst", ldr_cpu_rst, 1);
    chk("bad_done", ldr_done, 0);
    repeat (3) cyc(1'b1, 8'h00);
    chk("err_hold", ldr_err, 1);

    // Valid gaps.
    log_q.delete();
    ldr_last_addr = 8'd1;
    do_start();
    cyc(1'b1, 8'h05); cyc(1'b0, 8'hEE); cyc(1'b0, 8'hEE);
    cyc(1'b1, 8'h07); cyc(1'b0, 8'hEE); cyc(1'b1, 8'hF4);
    repeat (2) @(negedge ldr_clk);
    exp_q = {16'h0005, 16'h0107};
    check_log("gaps");
    chk("gaps_done", ldr_done, 1);

    // Restart coinciding with a byte: that byte is dropped.
    log_q.delete();
    ldr_last_addr = 8'd1;
    do_start();
    send(8'h11);
    ldr_start = 1'b1; ldr_in_valid = 1'b1; ldr_in_data = 8'h22;
    @(negedge ldr_clk);
    ldr_start = 1'b0; ldr_in_valid = 1'b0;
    send(8'h33); send(8'h44); send(8'h89);
    repeat (2) @(negedge ldr_clk);
    exp_q = {16'h0011, 16'h0033, 16'h0144};
    check_log("restart");
    chk("restart_done", ldr_done, 1);

    // Reset right after a transfer suppresses the pending write.
    log_q.delete();
    ldr_last_addr = 8'd3;
    do_start();
    ldr_in_valid = 1'b1; ldr_in_data = 8'hAA;
    @(posedge ldr_clk);
    #1 ldr_rst = 1'b1;
    ldr_in_valid = 1'b0;
    @(negedge ldr_clk);
    chk("mid_rst_wr", ldr_mem_wr_en, 0);
    chk("mid_rst_addr", ldr_mem_addr, 0);
    chk("mid_rst_data", ldr_mem_data, 0);
    chk("mid_rst_busy", ldr_busy, 0);
    @(negedge ldr_clk);
    ldr_rst = 1'b0;
    repeat (3) cyc(1'b1, 8'h99);
    exp_q = {};
    check_log("mid_rst");
    // Fresh single-byte load afterwards.
    ldr_last_addr = 8'd0;
    do_start();
    send(8'h5A); send(8'hA6);
    repeat (2) @(negedge ldr_clk);
    exp_q = {16'h005A};
    check_log("single");
    chk("single_done", ldr_done, 1);

    // Full address space.
    log_q.delete();
    ldr_last_addr = 8'd255;
    do_start();
    for (int i = 0; i < 256; i++) send(8'h01);
    chk("full_busy", ldr_busy, 1);
    send(8'h00);
    repeat (2) @(negedge ldr_clk);
    exp_q = {};
    for (int i = 0; i < 256; i++) exp_q.push_back({i[7:0], 8'h01});
    check_log("full");
    chk("full_done", ldr_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
